// File: rtl/text_grid_pkg.sv
// Shared constants, FSM state encoding and the logical-to-physical cell
// address helper for the text grid reader.
package text_grid_pkg;

  localparam int ROWS   = 15;
  localparam int COLS   = 40;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 6;
  localparam int ADDR_W = 10;
  localparam int CHAR_W = 8;
  localparam int CELL_W = 16;
  localparam int CELL_H = 32;

  localparam logic [CHAR_W-1:0] CLEAR_CODE = 8'hFF;
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h00;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
  localparam logic [9:0]        AREA_X    = 10'(COLS * CELL_W);
  localparam logic [9:0]        AREA_Y    = 10'(ROWS * CELL_H);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLR_ALL  = 2'd1;
  localparam logic [1:0] ST_CLR_LINE = 2'd2;

  // Rotates a logical row by base_row and flattens to row*40+col with shifts
  // only; callers guarantee row < ROWS and col < COLS.
  function automatic logic [ADDR_W-1:0] cellAddr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] baseRow);
    logic [ROW_W:0]   sum;
    logic [ADDR_W-1:0] phys;
    sum = {1'b0, row} + {1'b0, baseRow};
    if (sum >= 5'(ROWS)) sum = sum - 5'(ROWS);
    phys = {6'b0, sum[ROW_W-1:0]};
    return (phys << 5) + (phys << 3) + {4'b0, col};
  endfunction

endpackage

// File: rtl/text_grid_ram.sv
// ROWS*COLS x 8 simple dual-port character store: one write port and one
// synchronous read-first read port, written so it maps onto block RAM.
module text_grid_ram
  import text_grid_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [CHAR_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [CHAR_W-1:0] rd_data_o
);

  logic [CHAR_W-1:0] mem [ROWS*COLS];
  logic [CHAR_W-1:0] rd_data_q;

  // Write and read share one edge; the read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/text_grid_reader.sv
// Consumer side of the character feeder: owns the text store, applies writes,
// scrolls and clears, and serves pixel-addressed glyph lookups to the VGA stage.
// Optional blinking cursor: define TEXT_READER_CURSOR_EN.
module text_grid_reader
  import text_grid_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              wr_en,
  input  logic              push_up,
  input  logic              reset_call,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  output logic [CHAR_W-1:0] char_id,
  output logic [3:0]        glyph_x,
  output logic [4:0]        glyph_y,
  output logic              in_area,
  output logic              rd_valid,
  output logic              busy,
  output logic              cursor_hit
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] clr_last_q, clr_last_d;
  logic [ROW_W-1:0]  base_row_q, base_row_d;

  logic              ramWrEn;
  logic [ADDR_W-1:0] ramWrAddr;
  logic [CHAR_W-1:0] ramWrData;
  logic [ADDR_W-1:0] ramRdAddr;
  logic [CHAR_W-1:0] ramRdData;
  logic              wrOk;
  logic [ADDR_W-1:0] lineStart;

  logic              s0Valid_q, s0Area_q;
  logic [ROW_W-1:0]  s0Row_q;
  logic [COL_W-1:0]  s0Col_q;
  logic [3:0]        s0Gx_q;
  logic [4:0]        s0Gy_q;
  logic              s1Valid_q, s1Area_q, s1Hit_q;
  logic [3:0]        s1Gx_q;
  logic [4:0]        s1Gy_q;
  logic              hitNext;

  logic [CHAR_W-1:0] char_q;
  logic [3:0]        glyph_x_q;
  logic [4:0]        glyph_y_q;
  logic              in_area_q, rd_valid_q, cursor_hit_q;

  assign wrOk = wr_en && (wr_row <= LAST_ROW) && (wr_col <= LAST_COL) && (wr_char != CLEAR_CODE);
  assign lineStart = cellAddr('0, '0, base_row_q);

  // Clear FSM and base-row rotator; feeder writes only land while idle.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_last_d = clr_last_q;
    base_row_d = base_row_q;
    ramWrEn    = 1'b0;
    ramWrAddr  = wrOk ? cellAddr(wr_row, wr_col, base_row_q) : '0;
    ramWrData  = wr_char;
    case (state_q)
      ST_IDLE: begin
        if (reset_call) begin
          state_d    = ST_CLR_ALL;
          clr_ptr_d  = '0;
          clr_last_d = LAST_ADDR;
          base_row_d = '0;
        end else begin
          ramWrEn = wrOk;
          if (push_up) begin
            state_d    = ST_CLR_LINE;
            clr_ptr_d  = lineStart;
            clr_last_d = lineStart + ADDR_W'(COLS - 1);
            base_row_d = (base_row_q == LAST_ROW) ? '0 : base_row_q + 1'b1;
          end
        end
      end
      ST_CLR_ALL, ST_CLR_LINE: begin
        ramWrEn   = 1'b1;
        ramWrAddr = clr_ptr_q;
        ramWrData = BLANK_CHAR;
        if (reset_call) begin
          state_d    = ST_CLR_ALL;
          clr_ptr_d  = '0;
          clr_last_d = LAST_ADDR;
          base_row_d = '0;
        end else if (clr_ptr_q == clr_last_q) begin
          state_d = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset starts a full-screen clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_CLR_ALL;
      clr_ptr_q  <= '0;
      clr_last_q <= LAST_ADDR;
      base_row_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_last_q <= clr_last_d;
      base_row_q <= base_row_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Out-of-area requests read address 0 so the RAM never sees an illegal index.
  assign ramRdAddr = s0Area_q ? cellAddr(s0Row_q, s0Col_q, base_row_q) : '0;

  text_grid_ram u_ram (
    .clock     (clock),
    .wr_en_i   (ramWrEn),
    .wr_addr_i (ramWrAddr),
    .wr_data_i (ramWrData),
    .rd_addr_i (ramRdAddr),
    .rd_data_o (ramRdData)
  );

`ifdef TEXT_READER_CURSOR_EN
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [24:0]      blink_q;

  // Cursor follows the cell after the last accepted feeder write.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    if (reset_call) begin
      cur_row_d = '0;
      cur_col_d = '0;
    end else if (ramWrEn && (state_q == ST_IDLE)) begin
      if (wr_col == LAST_COL) begin
        cur_col_d = '0;
        cur_row_d = (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
      end else begin
        cur_col_d = wr_col + 1'b1;
        cur_row_d = wr_row;
      end
    end
  end

  // Cursor position and free-running blink counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_row_q <= '0;
      cur_col_q <= '0;
      blink_q   <= '0;
    end else begin
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      blink_q   <= blink_q + 1'b1;
    end
  end

  assign hitNext = s0Valid_q && s0Area_q && (s0Row_q == cur_row_q) &&
                   (s0Col_q == cur_col_q) && blink_q[24];
`else
  assign hitNext = 1'b0;
`endif

  // Three-register read pipeline: request capture, RAM read, output.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s0Valid_q    <= 1'b0;
      s0Area_q     <= 1'b0;
      s0Row_q      <= '0;
      s0Col_q      <= '0;
      s0Gx_q       <= '0;
      s0Gy_q       <= '0;
      s1Valid_q    <= 1'b0;
      s1Area_q     <= 1'b0;
      s1Hit_q      <= 1'b0;
      s1Gx_q       <= '0;
      s1Gy_q       <= '0;
      rd_valid_q   <= 1'b0;
      char_q       <= BLANK_CHAR;
      glyph_x_q    <= '0;
      glyph_y_q    <= '0;
      in_area_q    <= 1'b0;
      cursor_hit_q <= 1'b0;
    end else begin
      s0Valid_q    <= pix_valid;
      s0Area_q     <= (pix_x < AREA_X) && (pix_y < AREA_Y);
      s0Row_q      <= pix_y[8:5];
      s0Col_q      <= pix_x[9:4];
      s0Gx_q       <= pix_x[3:0];
      s0Gy_q       <= pix_y[4:0];
      s1Valid_q    <= s0Valid_q;
      s1Area_q     <= s0Area_q;
      s1Hit_q      <= hitNext;
      s1Gx_q       <= s0Gx_q;
      s1Gy_q       <= s0Gy_q;
      rd_valid_q   <= s1Valid_q;
      char_q       <= s1Area_q ? ramRdData : BLANK_CHAR;
      glyph_x_q    <= s1Gx_q;
      glyph_y_q    <= s1Gy_q;
      in_area_q    <= s1Area_q;
      cursor_hit_q <= s1Hit_q;
    end
  end

  assign char_id    = char_q;
  assign glyph_x    = glyph_x_q;
  assign glyph_y    = glyph_y_q;
  assign in_area    = in_area_q;
  assign rd_valid   = rd_valid_q;
  assign cursor_hit = cursor_hit_q;

endmodule

// File: tb/tb_text_grid_reader.sv
// Self-checking bench for text_grid_reader: a logical-screen model (rows are
// shifted on scroll) predicts every output; directed reads pin known values.
module tb_text_grid_reader;

  logic       clock;
  logic       reset_n;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic       wr_en, push_up, reset_call;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid;
  logic [7:0] char_id;
  logic [3:0] glyph_x;
  logic [4:0] glyph_y;
  logic       in_area, rd_valid, busy, cursor_hit;

  text_grid_reader dut (
    .clock(clock), .reset_n(reset_n),
    .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char), .wr_en(wr_en),
    .push_up(push_up), .reset_call(reset_call),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .char_id(char_id), .glyph_x(glyph_x), .glyph_y(glyph_y), .in_area(in_area),
    .rd_valid(rd_valid), .busy(busy), .cursor_hit(cursor_hit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;

  logic [7:0] scr [15][40];
  int busyRem;
  int curR, curC;
  int blinkCnt;

  bit         hasBusy  [8];
  bit         expBusy  [8];
  bit         hasRd    [8];
  bit         expValid [8];
  bit         expArea  [8];
  bit         expDc    [8];
  bit         expHit   [8];
  logic [7:0] expChar  [8];
  int         expGx    [8];
  int         expGy    [8];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  task automatic blankAll();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++)
        scr[r][c] = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs now driven, record
  // what the DUT must show, then wait for the following negedge.
  task automatic applyStimulus();
    int e, s, x, y, r, c;
    bit area;
    e = edgeNum + 1;
    if (!reset_n) begin
      busyRem = 600;
      blankAll();
      curR = 0; curC = 0; blinkCnt = 0;
    end else begin
      if (reset_call) begin
        busyRem = 600;
        blankAll();
        curR = 0; curC = 0;
      end else if (busyRem > 0) begin
        busyRem--;
      end else begin
        r = int'(wr_row);
        c = int'(wr_col);
        if (wr_en && r < 15 && c < 40 && wr_char != 8'hFF) begin
          scr[r][c] = wr_char;
          curC = c + 1;
          curR = r;
          if (curC == 40) begin
            curC = 0;
            curR = (r + 1) % 15;
          end
        end
        if (push_up) begin
          for (int rr = 0; rr < 14; rr++)
            for (int cc = 0; cc < 40; cc++)
              scr[rr][cc] = scr[rr+1][cc];
          for (int cc = 0; cc < 40; cc++) scr[14][cc] = 8'h00;
          busyRem = 40;
        end
      end
      blinkCnt++;
    end
    s = e % 8;
    hasBusy[s] = 1'b1;
    expBusy[s] = (busyRem > 0);
    x = int'(pix_x);
    y = int'(pix_y);
    area = (x < 640) && (y < 480);
    s = (e + 2) % 8;
    hasRd[s]    = 1'b1;
    expValid[s] = reset_n && pix_valid;
    expArea[s]  = area;
    expChar[s]  = area ? scr[y / 32][x / 16] : 8'h00;
    expDc[s]    = area && (busyRem > 0);
    expGx[s]    = x % 16;
    expGy[s]    = y % 32;
`ifdef TEXT_READER_CURSOR_EN
    expHit[s]   = expValid[s] && area && (y / 32 == curR) && (x / 16 == curC) &&
                  (((blinkCnt >> 24) & 1) == 1);
`else
    expHit[s]   = 1'b0;
`endif
    if (!reset_n)
      for (int k = 0; k < 3; k++) expValid[(e + k) % 8] = 1'b0;
    @(negedge clock);
  endtask

  // Compare every output against the model shortly after each rising edge.
  always @(posedge clock) begin
    int s;
    edgeNum = edgeNum + 1;
    #1;
    s = edgeNum % 8;
    if (hasBusy[s]) begin
      checkVal("busy", busy, expBusy[s]);
      hasBusy[s] = 1'b0;
    end
    if (hasRd[s]) begin
      checkVal("rd_valid", rd_valid, expValid[s]);
      if (expValid[s]) begin
        checkVal("in_area", in_area, expArea[s]);
        checkVal("glyph_x", glyph_x, expGx[s]);
        checkVal("glyph_y", glyph_y, expGy[s]);
        checkVal("cursor_hit", cursor_hit, expHit[s]);
        if (!expDc[s]) checkVal("char_id", char_id, expChar[s]);
      end
      hasRd[s] = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] eChar, input bit eArea,
                             input int eGx, input int eGy);
    checkVal({name, " valid"}, rd_valid, 1);
    checkVal({name, " char"}, char_id, eChar);
    checkVal({name, " area"}, in_area, eArea);
    checkVal({name, " gx"}, glyph_x, eGx);
    checkVal({name, " gy"}, glyph_y, eGy);
    checkVal({name, " hit"}, cursor_hit, 0);
  endtask

  task automatic readCell(input string name, input int x, input int y, input logic [7:0] eChar,
                          input bit eArea, input int eGx, input int eGy);
    pix_x = 10'(x); pix_y = 10'(y); pix_valid = 1'b1;
    applyStimulus();
    pix_valid = 1'b0;
    applyStimulus();
    checkVal({name, " not yet valid"}, rd_valid, 0);
    applyStimulus();
    checkOutput(name, eChar, eArea, eGx, eGy);
  endtask

  task automatic writeCell(input int r, input int c, input logic [7:0] ch);
    wr_row = 4'(r); wr_col = 6'(c); wr_char = ch; wr_en = 1'b1;
    applyStimulus();
    wr_en = 1'b0;
  endtask

  task automatic pulseScroll();
    push_up = 1'b1;
    applyStimulus();
    push_up = 1'b0;
  endtask

  // Count cycles with busy high; optionally attempt a write at (3,3) meanwhile.
  task automatic countBusy(input bit wrDuring, output int n);
    int guard;
    n = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      n++;
      if (wrDuring && n == 1) begin
        wr_row = 4'd3; wr_col = 6'd3; wr_char = 8'h55; wr_en = 1'b1;
      end
      applyStimulus();
      wr_en = 1'b0;
      guard++;
    end
    if (guard >= 2000) $display("[TB] FAIL busy timeout: got busy stuck, expected release");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0; wr_en = 1'b0;
    push_up = 1'b0; reset_call = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    busyRem = 600; curR = 0; curC = 0; blinkCnt = 0;
    blankAll();
    @(negedge clock);
    repeat (3) applyStimulus();
    checkVal("reset rd_valid", rd_valid, 0);
    checkVal("reset char_id", char_id, 8'h00);
    checkVal("reset glyph_x", glyph_x, 0);
    checkVal("reset glyph_y", glyph_y, 0);
    checkVal("reset in_area", in_area, 0);
    checkVal("reset busy", busy, 1);
    checkVal("reset cursor_hit", cursor_hit, 0);

    reset_n = 1'b1;
    countBusy(1'b0, n);
    checkVal("initial clear length", n, 600);
    readCell("read 0,0", 0, 0, 8'h00, 1'b1, 0, 0);

    writeCell(2, 5, 8'h41);
    readCell("read 2,5", 80, 64, 8'h41, 1'b1, 0, 0);
    readCell("read 2,5 offs", 85, 70, 8'h41, 1'b1, 5, 6);

    writeCell(0, 0, 8'h42);
    pulseScroll();
    countBusy(1'b0, n);
    checkVal("line clear length", n, 40);
    readCell("new bottom row", 0, 448, 8'h00, 1'b1, 0, 0);
    readCell("0x42 gone", 0, 0, 8'h00, 1'b1, 0, 0);
    readCell("0x41 scrolled", 80, 32, 8'h41, 1'b1, 0, 0);
    writeCell(14, 0, 8'h43);
    readCell("bottom write", 0, 448, 8'h43, 1'b1, 0, 0);

    writeCell(15, 0, 8'h77);
    writeCell(3, 40, 8'h78);
    readCell("col 40 dropped", 0, 128, 8'h00, 1'b1, 0, 0);
    writeCell(5, 5, 8'h44);
    writeCell(5, 5, 8'hFF);
    readCell("FF not stored", 80, 160, 8'h44, 1'b1, 0, 0);

    writeCell(6, 6, 8'h10);
    pix_x = 10'd96; pix_y = 10'd192; pix_valid = 1'b1;
    applyStimulus();
    pix_valid = 1'b0;
    wr_row = 4'd6; wr_col = 6'd6; wr_char = 8'h20; wr_en = 1'b1;
    applyStimulus();
    wr_en = 1'b0;
    applyStimulus();
    checkOutput("read-first", 8'h10, 1'b1, 0, 0);
    readCell("after overwrite", 96, 192, 8'h20, 1'b1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      pix_x = 10'((i * 41) % 700); pix_y = 10'((i * 37) % 520); pix_valid = 1'b1;
      applyStimulus();
    end
    pix_valid = 1'b0;
    repeat (3) applyStimulus();

    for (int r = 0; r < 15; r++) writeCell(r, 5, 8'(8'h60 + r));
    for (int k = 0; k < 15; k++) begin
      pulseScroll();
      countBusy(1'b0, n);
      checkVal("scroll clear length", n, 40);
    end
    for (int r = 0; r < 15; r++) readCell("after 15 scrolls", 80, r * 32, 8'h00, 1'b1, 0, 0);

    writeCell(6, 6, 8'h21);
    pulseScroll();
    repeat (9) applyStimulus();
    reset_call = 1'b1;
    applyStimulus();
    reset_call = 1'b0;
    countBusy(1'b1, n);
    checkVal("restarted clear length", n, 600);
    readCell("write during busy", 48, 96, 8'h00, 1'b1, 0, 0);
    readCell("cleared by reset_call", 96, 160, 8'h00, 1'b1, 0, 0);

    readCell("x edge", 640, 0, 8'h00, 1'b0, 0, 0);
    readCell("y edge", 0, 480, 8'h00, 1'b0, 0, 0);
    writeCell(14, 39, 8'h7E);
    readCell("last pixel", 639, 479, 8'h7E, 1'b1, 15, 31);
    writeCell(0, 0, 8'h01);
    readCell("cursor cell", 16, 0, 8'h00, 1'b1, 0, 0);

    pix_x = 10'd80; pix_y = 10'd64; pix_valid = 1'b1;
    applyStimulus();
    pix_valid = 1'b0;
    reset_n = 1'b0;
    applyStimulus();
    applyStimulus();
    checkVal("flush on reset", rd_valid, 0);
    reset_n = 1'b1;
    countBusy(1'b0, n);
    checkVal("clear after reset", n, 600);
    repeat (3) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
